// File: rtl/i2c_pkg.sv
// Shared types and constants for the register-mapped I2C target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter and edge detect.
// Output only follows the input after FILTER_LEN consecutive identical samples.
module i2c_in_filter #(
  parameter int FILTER_LEN = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = 3;

  logic          s1_q;
  logic          s2_q;
  logic          dout_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;

  // Idle bus level is high, so every stage presets to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      dout_q <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= dout_q;
      if (s2_q == dout_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        dout_q <= s2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign dout = dout_q;
  assign rise = dout_q & ~prev_q;
  assign fall = ~dout_q & prev_q;

endmodule

// File: rtl/i2c_slave_regmap.sv
// I2C target with pointer byte, burst read/write into a register bank and
// pointer auto-increment. Register strobes are one clk wide and registered.
module i2c_slave_regmap
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADRS       = 7'h50,
  parameter int         NREGS      = 16,
  parameter int         FILTER_LEN = 2,
  parameter bit         AUTO_INC   = 1'b1,
  localparam int        PTR_W      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scl,
  inout  wire              sda,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  output logic             reg_re,
  input  logic [7:0]       reg_rdata,
  output logic             busy,
  output logic             nack_err,
  output i2c_state_t       state_dbg
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (scl),
    .dout    (scl_f),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sda),
    .dout    (sda_f),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  i2c_state_t       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             nack_q, nack_d;
  logic             busy_q, busy_d;
  logic             sda_oe_q, sda_oe_d;
  logic             rw_q, rw_d;
  logic [1:0]       rd_dly_q, rd_dly_d;

  logic             start_det;
  logic             stop_det;
  logic             last_bit;
  logic [7:0]       byte_w;
  logic [PTR_W-1:0] ptr_next;

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign byte_w    = {shift_q[6:0], sda_f};
  assign ptr_next  = !AUTO_INC ? ptr_q :
                     (ptr_q == PTR_W'(NREGS - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      rw_q      <= 1'b0;
      rd_dly_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
      sda_oe_q  <= sda_oe_d;
      rw_q      <= rw_d;
      rd_dly_q  <= rd_dly_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    nack_d    = 1'b0;
    busy_d    = busy_q;
    sda_oe_d  = sda_oe_q;
    rw_d      = rw_q;
    rd_dly_d  = rd_dly_q;

    // Read data is captured exactly two clocks after the reg_re strobe.
    if (rd_dly_q != 2'd0) begin
      rd_dly_d = rd_dly_q - 2'd1;
      if (rd_dly_q == 2'd1) shift_d = reg_rdata;
    end

    if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d   = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (byte_w[7:1] == ADRS) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_w[0];
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        // Ack phases: drive low on the fall, leave on the 9th rise.
        ADDR_ACK: begin
          if (scl_fall) sda_oe_d = ~ACK;
          if (scl_rise) begin
            bit_cnt_d = '0;
            if (rw_q == I2C_RW_READ) begin
              state_d  = RDATA;
              re_d     = 1'b1;
              addr_d   = ptr_q;
              rd_dly_d = 2'd2;
            end else begin
              state_d = PTR;
            end
          end
        end
        PTR: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d   = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (int'(byte_w) < NREGS) begin
                ptr_d   = byte_w[PTR_W-1:0];
                state_d = PTR_ACK;
              end else begin
                nack_d  = 1'b1;
                state_d = IGNORE;
              end
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) sda_oe_d = ~ACK;
          if (scl_rise) begin
            bit_cnt_d = '0;
            state_d   = WDATA;
          end
        end
        WDATA: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d   = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              wdata_d = byte_w;
              ptr_d   = ptr_next;
              state_d = WDATA_ACK;
            end
          end
        end
        // A 1 bit is sent by releasing the line, a 0 by pulling it low.
        RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b1};
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              ptr_d   = ptr_next;
              state_d = RDATA_ACK;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            if (sda_f == ACK) begin
              bit_cnt_d = '0;
              state_d   = RDATA;
              re_d      = 1'b1;
              addr_d    = ptr_q;
              rd_dly_d  = 2'd2;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IGNORE: sda_oe_d = 1'b0;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign nack_err  = nack_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Bench for i2c_slave_regmap: bit-banged I2C master, a register bank model and
// a per-cycle strobe checker fed from expected queues.
module tb_i2c_slave_regmap;
  import i2c_pkg::*;

  localparam logic [6:0] ADRS  = 7'h50;
  localparam int         NREGS = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       m_scl = 1'b1;
  logic       m_sda_oe = 1'b0;
  wire        sda_w;
  pullup (sda_w);
  assign sda_w = m_sda_oe ? 1'b0 : 1'bz;

  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       nack_err;
  i2c_state_t state_dbg;

  i2c_slave_regmap #(
    .ADRS       (ADRS),
    .NREGS      (NREGS),
    .FILTER_LEN (2),
    .AUTO_INC   (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (m_scl),
    .sda       (sda_w),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .nack_err  (nack_err),
    .state_dbg (state_dbg)
  );

  // ---------------- model state / scoreboard ----------------
  int          n_err = 0;
  int          n_checks = 0;
  logic [7:0]  bank [NREGS];
  int          mptr = 0;
  int          nack_exp = 0;
  int          nack_seen = 0;
  logic [11:0] exp_we_q[$];
  logic [3:0]  exp_re_q[$];
  logic [7:0]  wr_buf[$];
  logic [7:0]  rd_got[$];
  int          glitch_at = -1;
  int          glitch_kind = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_checks++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected no strobe at %0t", name, act, $time);
  endtask

  // Bank answers a read strobe on the next clock; otherwise reg_rdata is noise.
  always @(posedge clk)
    reg_rdata <= reg_re ? bank[reg_addr] : 8'($urandom);

  always @(negedge clk) begin
    if (reset_n) begin
      if (reg_we || reg_re) check("strobe_excl", {31'd0, reg_we & reg_re}, 32'd0);
      if (reg_we) begin
        if (exp_we_q.size() == 0) fail("we_unexpected", {20'd0, reg_addr, reg_wdata});
        else check("we_addr_data", {20'd0, reg_addr, reg_wdata}, {20'd0, exp_we_q.pop_front()});
      end
      if (reg_re) begin
        if (exp_re_q.size() == 0) fail("re_unexpected", {28'd0, reg_addr});
        else check("re_addr", {28'd0, reg_addr}, {28'd0, exp_re_q.pop_front()});
      end
      if (nack_err) nack_seen++;
    end
  end

  // ---------------- bus driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    wait_clk(8);
    m_sda_oe = ~b;
    wait_clk(8);
    m_scl = 1'b1;
    wait_clk(6);
    if (glitch_at == 0) begin
      if (glitch_kind == 1) m_scl = 1'b0; else m_sda_oe = ~m_sda_oe;
      wait_clk(1);
      if (glitch_kind == 1) m_scl = 1'b1; else m_sda_oe = ~m_sda_oe;
    end else begin
      wait_clk(1);
    end
    if (glitch_at >= 0) glitch_at--;
    wait_clk(9);
    m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clk(8);
    m_sda_oe = 1'b0;
    wait_clk(8);
    m_scl = 1'b1;
    wait_clk(8);
    b = sda_w;
    wait_clk(8);
    m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic mnack, output logic [7:0] v);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bt);
      v[i] = bt;
    end
    send_bit(mnack);
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      wait_clk(8);
      m_sda_oe = 1'b0;
      wait_clk(8);
      m_scl = 1'b1;
    end
    wait_clk(8);
    m_sda_oe = 1'b1;
    wait_clk(8);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(8);
    m_sda_oe = 1'b1;
    wait_clk(8);
    m_scl = 1'b1;
    wait_clk(8);
    m_sda_oe = 1'b0;
    wait_clk(16);
  endtask

  // ---------------- transaction tasks with model ----------------
  task automatic do_write(input logic [7:0] p);
    logic ack;
    logic bad;
    bad = (int'(p) >= NREGS);
    i2c_start();
    write_byte({ADRS, I2C_RW_WRITE}, ack);
    check("w_addr_ack", {31'd0, ack}, {31'd0, ACK});
    check("w_busy", {31'd0, busy}, 32'd1);
    write_byte(p, ack);
    check("w_ptr_ack", {31'd0, ack}, {31'd0, bad});
    if (bad) nack_exp++;
    else mptr = int'(p);
    check("nack_pulses", nack_seen, nack_exp);
    foreach (wr_buf[i]) begin
      if (!bad) begin
        exp_we_q.push_back({4'(mptr), wr_buf[i]});
        bank[mptr] = wr_buf[i];
        mptr = (mptr + 1) % NREGS;
      end
      write_byte(wr_buf[i], ack);
      check("w_data_ack", {31'd0, ack}, {31'd0, bad});
    end
    i2c_stop();
    check("w_busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_read(input int n, input bit use_ptr, input logic [7:0] p);
    logic ack;
    logic [7:0] v;
    rd_got.delete();
    i2c_start();
    if (use_ptr) begin
      write_byte({ADRS, I2C_RW_WRITE}, ack);
      check("r_addrw_ack", {31'd0, ack}, {31'd0, ACK});
      write_byte(p, ack);
      check("r_ptr_ack", {31'd0, ack}, {31'd0, ACK});
      mptr = int'(p);
      i2c_start();
    end
    for (int i = 0; i < n; i++) exp_re_q.push_back(4'((mptr + i) % NREGS));
    write_byte({ADRS, I2C_RW_READ}, ack);
    check("r_addr_ack", {31'd0, ack}, {31'd0, ACK});
    check("r_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? NACK : ACK, v);
      check("r_data", {24'd0, v}, {24'd0, bank[mptr]});
      rd_got.push_back(v);
      mptr = (mptr + 1) % NREGS;
    end
    wait_clk(8);
    check("r_release", {31'd0, sda_w}, 32'd1);
    i2c_stop();
    check("r_busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_badaddr(input logic [6:0] a);
    logic ack;
    i2c_start();
    write_byte({a, 1'($urandom)}, ack);
    check("bad_addr_nack", {31'd0, ack}, {31'd0, NACK});
    check("bad_busy", {31'd0, busy}, 32'd0);
    write_byte(8'($urandom), ack);
    check("bad_data_nack", {31'd0, ack}, {31'd0, NACK});
    i2c_stop();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] a;
    logic       ack;
    for (int i = 0; i < NREGS; i++) bank[i] = 8'($urandom);

    wait_clk(4);
    check("rst_sda", {31'd0, sda_w}, 32'd1);
    check("rst_we_re", {30'd0, reg_we, reg_re}, 32'd0);
    check("rst_addr", {28'd0, reg_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_nack", {31'd0, nack_err}, 32'd0);
    check("rst_state", {28'd0, state_dbg}, {28'd0, IDLE});
    reset_n = 1'b1;
    wait_clk(20);

    // Write burst 0x11 0x22 0x33 at pointer 3, then read it back.
    wr_buf = '{8'h11, 8'h22, 8'h33};
    do_write(8'h03);
    do_read(3, 1'b1, 8'h03);
    check("pin_rd0", {24'd0, rd_got[0]}, 32'h11);
    check("pin_rd1", {24'd0, rd_got[1]}, 32'h22);
    check("pin_rd2", {24'd0, rd_got[2]}, 32'h33);

    // Random read across the wrap from 15 to 0.
    bank[14] = 8'hCD;
    bank[15] = 8'hAD;
    bank[0]  = 8'h5A;
    do_read(3, 1'b1, 8'h0E);
    check("pin_wrap0", {24'd0, rd_got[0]}, 32'hCD);
    check("pin_wrap1", {24'd0, rd_got[1]}, 32'hAD);
    check("pin_wrap2", {24'd0, rd_got[2]}, 32'h5A);

    // Wrong address, then a normal transfer.
    do_badaddr(7'h51);
    wr_buf = '{8'h77};
    do_write(8'h09);

    // Out-of-range pointer: NACK, single nack_err pulse, data ignored.
    wr_buf = '{8'hDE, 8'hAD};
    do_write(8'h10);
    check("pin_nack_cnt", nack_seen, 32'd1);

    // Single-clock glitches on SCL and on SDA while SCL is high.
    glitch_kind = 1;
    glitch_at   = 20;
    wr_buf = '{8'hA5, 8'h3C};
    do_write(8'h05);
    glitch_kind = 2;
    glitch_at   = 20;
    wr_buf = '{8'hA5, 8'h3C};
    do_write(8'h0A);
    glitch_kind = 2;
    glitch_at   = 26;
    wr_buf = '{8'hA5, 8'h3C};
    do_write(8'h0C);
    do_read(2, 1'b1, 8'h0C);
    check("pin_glitch0", {24'd0, rd_got[0]}, 32'hA5);
    check("pin_glitch1", {24'd0, rd_got[1]}, 32'h3C);

    // Reset while the target is holding the address ACK low.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? I2C_RW_WRITE : ADRS[i-1]);
    m_sda_oe = 1'b0;
    wait_clk(8);
    check("ack_driven", {31'd0, sda_w}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_sda", {31'd0, sda_w}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_strobes", {29'd0, reg_we, reg_re, nack_err}, 32'd0);
    check("mid_rst_addr", {28'd0, reg_addr}, 32'd0);
    check("mid_rst_state", {28'd0, state_dbg}, {28'd0, IDLE});
    m_scl = 1'b1;
    wait_clk(8);
    reset_n = 1'b1;
    mptr = 0;
    wait_clk(16);
    wr_buf = '{8'h42};
    do_write(8'h07);
    do_read(1, 1'b0, 8'h00);

    // Randomized traffic.
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          wr_buf.delete();
          repeat ($urandom_range(0, 3)) wr_buf.push_back(8'($urandom));
          do_write(8'($urandom_range(0, 17)));
        end
        1: do_read($urandom_range(1, 3), 1'b0, 8'h00);
        2: do_read($urandom_range(1, 3), 1'b1, 8'($urandom_range(0, 15)));
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == ADRS) a = a ^ 7'h01;
          do_badaddr(a);
        end
      endcase
    end

    // Read after a stretch of random traffic must follow the model pointer.
    i2c_start();
    exp_re_q.push_back(4'(mptr));
    write_byte({ADRS, I2C_RW_READ}, ack);
    check("final_addr_ack", {31'd0, ack}, {31'd0, ACK});
    begin
      logic [7:0] v;
      read_byte(NACK, v);
      check("final_data", {24'd0, v}, {24'd0, bank[mptr]});
    end
    i2c_stop();

    wait_clk(10);
    check("we_q_empty", exp_we_q.size(), 32'd0);
    check("re_q_empty", exp_re_q.size(), 32'd0);
    check("nack_total", nack_seen, nack_exp);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
